// File: rtl/spi_request_arbiter.sv
// Round-robin sharing of one SPI master: a grant appears 1 cycle after req is seen in IDLE, with spi_start.
// One start runs WORDS_PER_START cs_n frames; no backpressure, and clients hold off until their done pulse.
module spi_request_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_START = 2,
  parameter int TIMEOUT_CYC     = 4096
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [N_REQ-1:0]                            req,
  input  logic [N_REQ*WORDS_PER_START*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]                            gnt,
  output logic [N_REQ-1:0]                            done,
  output logic [WORDS_PER_START*DATA_WIDTH-1:0]       rsp_data,
  output logic                                        err,
  output logic                                        busy,
  output logic                                        spi_start,
  output logic [DATA_WIDTH-1:0]                       spi_data_in,
  input  logic                                        spi_cs_n,
  input  logic [DATA_WIDTH-1:0]                       spi_data_out
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int FC_W  = $clog2(WORDS_PER_START) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int BW    = WORDS_PER_START * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_DONE} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q, rr_ptr_q, rr_nxt, win_idx;
  logic                   win_vld;
  logic [BW-1:0]          bundle_q, win_bundle, rsp_q;
  logic [DATA_WIDTH-1:0]  data_in_q, nxt_word;
  logic [FC_W-1:0]        frame_cnt_q;
  logic [WD_W-1:0]        wd_q;
  logic [N_REQ-1:0]       gnt_q, done_q;
  logic                   cs_n_q, err_q, start_q;
  logic                   rise, wd_last, last_frame;
  int                     best, off;

  assign rise       = !cs_n_q && spi_cs_n;
  assign wd_last    = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign last_frame = (frame_cnt_q == FC_W'(WORDS_PER_START - 1));
  assign rr_nxt     = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Winner is the set request at the smallest distance from rr_ptr, counting upwards modulo N_REQ.
  always_comb begin
    win_vld    = |req;
    win_idx    = '0;
    win_bundle = '0;
    best       = N_REQ;
    off        = 0;
    for (int n = 0; n < N_REQ; n++) begin
      off = (n + N_REQ - int'(rr_ptr_q)) % N_REQ;
      if (req[n] && off < best) begin
        best    = off;
        win_idx = IDX_W'(n);
      end
    end
    for (int n = 0; n < N_REQ; n++) begin
      if (IDX_W'(n) == win_idx) win_bundle = req_data[n*BW +: BW];
    end
  end

  always_comb begin
    nxt_word = '0;
    for (int k = 0; k < WORDS_PER_START; k++) begin
      if (k == int'(frame_cnt_q) + 1) nxt_word = bundle_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      bundle_q    <= '0;
      rsp_q       <= '0;
      data_in_q   <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      cs_n_q      <= 1'b1;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      cs_n_q <= spi_cs_n;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            idx_q     <= win_idx;
            bundle_q  <= win_bundle;
            data_in_q <= win_bundle[DATA_WIDTH-1:0];
            gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            start_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q     <= 1'b0;
          frame_cnt_q <= '0;
          wd_q        <= '0;
          state_q     <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!spi_cs_n) begin
            wd_q    <= '0;
            state_q <= S_WAIT_HIGH;
          end else if (wd_last) begin
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rise) begin
            for (int k = 0; k < WORDS_PER_START; k++) begin
              if (k == int'(frame_cnt_q)) rsp_q[k*DATA_WIDTH +: DATA_WIDTH] <= spi_data_out;
            end
            if (last_frame) begin
              done_q  <= gnt_q;
              state_q <= S_DONE;
            end else begin
              // Next word goes out on the rise edge itself; the master samples it shortly after.
              frame_cnt_q <= frame_cnt_q + 1'b1;
              data_in_q   <= nxt_word;
              wd_q        <= '0;
              state_q     <= S_WAIT_LOW;
            end
          end else if (wd_last) begin
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q   <= '0;
          err_q    <= 1'b0;
          gnt_q    <= '0;
          rr_ptr_q <= rr_nxt;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_data    = rsp_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);
  assign spi_start   = start_q;
  assign spi_data_in = data_in_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: stimulus queues expected grants/responses, monitors pop and compare on done.
`timescale 1ns/1ps
module tb_spi_request_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam logic [15:0] W0 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  localparam logic [15:0] W1 [4] = '{16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC};
  localparam int ORD  [5] = '{0, 1, 2, 3, 0};
  localparam int ORD6 [3] = '{0, 1, 0};

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] rsp;
    logic        err;
    logic        chk_mosi;
    logic [15:0] m0;
    logic [15:0] m1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req, gnt, done;
  logic [N*2*DW-1:0] req_data;
  logic [2*DW-1:0] rsp_data;
  logic            err, busy, spi_start, spi_cs_n;
  logic [DW-1:0]   spi_data_in, spi_data_out;

  logic [N-1:0]    req1, gnt1, done1;
  logic [N*DW-1:0] req_data1;
  logic [DW-1:0]   rsp_data1, data_in1, data_out1;
  logic            err1, busy1, start1, cs_n1;

  spi_request_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .WORDS_PER_START(2), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .err(err), .busy(busy), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_cs_n(spi_cs_n), .spi_data_out(spi_data_out));

  spi_request_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .WORDS_PER_START(1), .TIMEOUT_CYC(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_data(req_data1), .gnt(gnt1), .done(done1),
    .rsp_data(rsp_data1), .err(err1), .busy(busy1), .spi_start(start1),
    .spi_data_in(data_in1), .spi_cs_n(cs_n1), .spi_data_out(data_out1));

  exp_t        exp_q[$];
  exp_t        exp1_q[$];
  logic [31:0] slv_rsp_q[$];
  logic [15:0] obs_m0, obs_m1, obs1;
  bit          slave_dead = 1'b0;
  bit          slave_busy = 1'b0;
  bit          mon_en = 1'b0;
  int          starts1 = 0;
  int          slv1_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no DUT event within cycle budget, expected one (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk_exp(input logic [3:0] g, input logic [31:0] r, input logic er,
                                  input logic cm, input logic [15:0] m0, input logic [15:0] m1);
    exp_t e;
    e.gnt = g; e.rsp = r; e.err = er; e.chk_mosi = cm; e.m0 = m0; e.m1 = m1;
    return e;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},     64'(gnt), 64'(0));
    chk({tag, "_done"},    64'(done), 64'(0));
    chk({tag, "_rsp"},     64'(rsp_data), 64'(0));
    chk({tag, "_err"},     64'(err), 64'(0));
    chk({tag, "_busy"},    64'(busy), 64'(0));
    chk({tag, "_start"},   64'(spi_start), 64'(0));
    chk({tag, "_data_in"}, 64'(spi_data_in), 64'(0));
  endtask

  task automatic slv_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // SPI master model for the 2-word instance; aborts its frames if reset is seen.
  initial begin
    logic [31:0] r;
    bit ab;
    spi_cs_n = 1'b1;
    spi_data_out = '0;
    obs_m0 = '0;
    obs_m1 = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && spi_start && !slave_dead) begin
        slave_busy = 1'b1;
        ab = 1'b0;
        r = (slv_rsp_q.size() != 0) ? slv_rsp_q.pop_front() : 32'h0;
        for (int f = 0; f < 2; f++) begin
          slv_wait(2, ab);
          if (ab) break;
          spi_cs_n = 1'b0;
          if (f == 0) obs_m0 = spi_data_in;
          else        obs_m1 = spi_data_in;
          slv_wait(3, ab);
          spi_data_out = (f == 0) ? r[15:0] : r[31:16];
          spi_cs_n = 1'b1;
          if (ab) break;
        end
        spi_cs_n = 1'b1;
        slave_busy = 1'b0;
      end
    end
  end

  initial begin
    bit ab;
    cs_n1 = 1'b1;
    data_out1 = '0;
    obs1 = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && start1) begin
        ab = 1'b0;
        slv_wait(2, ab);
        cs_n1 = 1'b0;
        obs1 = data_in1;
        slv_wait(3, ab);
        data_out1 = 16'(16'h6000 + slv1_cnt);
        slv1_cnt++;
        cs_n1 = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy) chk("gnt_onehot", 64'($onehot(gnt)), 64'(1));
        if (spi_start) begin
          if (exp_q.size() == 0) chk("unexpected_start", 64'(spi_start), 64'(0));
          else                   chk("gnt_at_start", 64'(gnt), 64'(exp_q[0].gnt));
        end
        if ((|done) || err) begin
          if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("done_vec", 64'(done), 64'(e.gnt));
            chk("rsp_data", 64'(rsp_data), 64'(e.rsp));
            chk("err", 64'(err), 64'(e.err));
            chk("gnt_with_done", 64'(gnt), 64'(e.gnt));
            if (e.chk_mosi) begin
              chk("mosi_word0", 64'(obs_m0), 64'(e.m0));
              chk("mosi_word1", 64'(obs_m1), 64'(e.m1));
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (start1) starts1++;
        if (|done1) begin
          chk("t6_starts_per_done", 64'(starts1), 64'(1));
          starts1 = 0;
          if (exp1_q.size() == 0) chk("t6_unexpected_done", 64'(done1), 64'(0));
          else begin
            e = exp1_q.pop_front();
            chk("t6_done_vec", 64'(done1), 64'(e.gnt));
            chk("t6_rsp_data", 64'(rsp_data1), 64'(e.rsp));
            chk("t6_err", 64'(err1), 64'(0));
            chk("t6_mosi", 64'(obs1), 64'(e.m0));
          end
        end
      end
    end
  end

  task automatic req_until_gnt(input logic [3:0] v, input string name);
    bit ok = 1'b0;
    @(negedge clk);
    req = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((gnt & v) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
    if (!ok) tmo(name);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  cnt;
    bit  ok;
    logic [31:0] r;
    rst_n = 1'b1;
    req = '0; req1 = '0; req_data = '0; req_data1 = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // T1: single requester, two frames
    req_data[31:0] = {16'hBEEF, 16'h1234};
    slv_rsp_q.push_back({16'h5A5A, 16'hA5A5});
    exp_q.push_back(mk_exp(4'b0001, 32'h5A5A_A5A5, 1'b0, 1'b1, 16'h1234, 16'hBEEF));
    req_until_gnt(4'b0001, "t1_grant");
    wait_drain("t1_drain");
    chk("t1_gnt_after", 64'(gnt), 64'(0));

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: all requesting, round-robin order 0,1,2,3,0
    for (int n = 0; n < N; n++) req_data[n*32 +: 32] = {W1[n], W0[n]};
    for (int t = 0; t < 5; t++) begin
      r = {16'(16'hD000 + t), 16'(16'hC000 + t)};
      slv_rsp_q.push_back(r);
      exp_q.push_back(mk_exp(4'b0001 << ORD[t], r, 1'b0, 1'b1, W0[ORD[t]], W1[ORD[t]]));
    end
    @(negedge clk);
    req = 4'b1111;
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (spi_start) cnt++;
      if (cnt == 5) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
    if (!ok) tmo("t2_five_grants");
    wait_drain("t2_drain");

    // T3: one-cycle request pulse still completes
    slv_rsp_q.push_back({16'hC3C3, 16'h3C3C});
    exp_q.push_back(mk_exp(4'b0100, 32'hC3C3_3C3C, 1'b0, 1'b1, W0[2], W1[2]));
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    wait_drain("t3_drain");
    chk("t3_gnt_after", 64'(gnt), 64'(0));

    // T4: dead master, watchdog fires; rsp_data keeps previous contents
    slave_dead = 1'b1;
    exp_q.push_back(mk_exp(4'b0001, 32'hC3C3_3C3C, 1'b1, 1'b0, 16'h0, 16'h0));
    req_until_gnt(4'b0001, "t4_grant");
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (done[0]) break;
    end
    chk("t4_issue_to_done_cycles", 64'(cnt), 64'(9));
    @(negedge clk);
    chk("t4_busy_after", 64'(busy), 64'(0));
    slave_dead = 1'b0;
    wait_drain("t4_drain");

    // T5: reset while the first frame is in flight
    slv_rsp_q.push_back({16'h7777, 16'h6666});
    exp_q.push_back(mk_exp(4'b0010, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0));
    req_until_gnt(4'b0010, "t5_grant");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!spi_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo("t5_cs_low");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("t5_abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!slave_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo("t5_master_idle");
    chk("t5_no_done_after_abort", 64'(done), 64'(0));
    slv_rsp_q.delete();
    slv_rsp_q.push_back({16'h0F0F, 16'hF0F0});
    exp_q.push_back(mk_exp(4'b0010, 32'h0F0F_F0F0, 1'b0, 1'b1, W0[1], W1[1]));
    req_until_gnt(4'b0010, "t5_regrant");
    wait_drain("t5_drain");

    // T6: single-word instance, one start per done
    for (int n = 0; n < N; n++) req_data1[n*16 +: 16] = W0[n];
    for (int t = 0; t < 3; t++)
      exp1_q.push_back(mk_exp(4'b0001 << ORD6[t], 32'(16'(16'h6000 + t)), 1'b0, 1'b1, W0[ORD6[t]], 16'h0));
    @(negedge clk);
    req1 = 4'b0011;
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start1) cnt++;
      if (cnt == 3) begin
        ok = 1'b1;
        break;
      end
    end
    req1 = '0;
    if (!ok) tmo("t6_three_grants");
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp1_q.size() == 0 && !busy1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo("t6_drain");
    chk("t6_gnt_after", 64'(gnt1), 64'(0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
